// File: rtl/ram_access_arbiter.sv
// Two-requester arbiter for a single-port command RAM. A grant is held for a whole
// transaction (address word through write data or read completion), with a stall timeout.
module ram_access_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  output logic [7:0] req0_rdata,
  output logic       req0_rvalid,
  input  logic [9:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] req1_rdata,
  output logic       req1_rvalid,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic       busy,
  output logic       err_proto,
  output logic       err_timeout
);

  typedef enum logic [2:0] {IDLE, LOCK0, LOCK1, WAIT_RD0, WAIT_RD1} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [9:0]        ram_din_q, ram_din_d;
  logic              ram_rx_valid_q, ram_rx_valid_d;
  logic [7:0]        rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic              err_proto_q, err_proto_d;
  logic              err_timeout_q, err_timeout_d;

  logic              acc0, acc1, acc;
  logic [9:0]        word;
  logic              expire;

  // In IDLE the grant goes to the only valid requester, or on a tie to the one not granted last.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = req0_valid && (!req1_valid || last_grant_q);
        req1_ready = req1_valid && (!req0_valid || !last_grant_q);
      end
      LOCK0:   req0_ready = 1'b1;
      LOCK1:   req1_ready = 1'b1;
      default: ;
    endcase
  end

  assign acc0   = req0_valid && req0_ready;
  assign acc1   = req1_valid && req1_ready;
  assign acc    = acc0 || acc1;
  assign word   = acc1 ? req1_data : req0_data;
  assign expire = (cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    ram_din_d      = ram_din_q;
    ram_rx_valid_d = 1'b0;
    rdata0_d       = rdata0_q;
    rdata1_d       = rdata1_q;
    rvalid0_d      = 1'b0;
    rvalid1_d      = 1'b0;
    err_proto_d    = 1'b0;
    err_timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (acc) begin
          if (!word[8]) begin
            ram_din_d      = word;
            ram_rx_valid_d = 1'b1;
            state_d        = acc1 ? LOCK1 : LOCK0;
            last_grant_d   = acc1;
            cnt_d          = '0;
          end else begin
            // Data or read command with no preceding address: consumed and dropped.
            err_proto_d = 1'b1;
          end
        end
      end

      LOCK0, LOCK1: begin
        if (acc) begin
          ram_din_d      = word;
          ram_rx_valid_d = 1'b1;
          cnt_d          = '0;
          case (word[9:8])
            2'b01:   state_d = IDLE;
            2'b11:   state_d = (state_q == LOCK1) ? WAIT_RD1 : WAIT_RD0;
            default: ;
          endcase
        end else if (expire) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      WAIT_RD0, WAIT_RD1: begin
        // Returning data takes priority over a timeout expiring in the same cycle.
        if (ram_tx_valid) begin
          if (state_q == WAIT_RD1) begin
            rdata1_d  = ram_dout;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = ram_dout;
            rvalid0_d = 1'b1;
          end
          state_d = IDLE;
          cnt_d   = '0;
        end else if (expire) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      cnt_q          <= '0;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
      rvalid0_q      <= 1'b0;
      rvalid1_q      <= 1'b0;
      err_proto_q    <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      rdata0_q       <= rdata0_d;
      rdata1_q       <= rdata1_d;
      rvalid0_q      <= rvalid0_d;
      rvalid1_q      <= rvalid1_d;
      err_proto_q    <= err_proto_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
  assign req0_rdata   = rdata0_q;
  assign req0_rvalid  = rvalid0_q;
  assign req1_rdata   = rdata1_q;
  assign req1_rvalid  = rvalid1_q;
  assign busy         = (state_q != IDLE);
  assign err_proto    = err_proto_q;
  assign err_timeout  = err_timeout_q;

endmodule
